strobe_debouncer: RTL
=====================

Name: strobe_debouncer

Overview:
- Debounces and qualifies one asynchronous input, sampling only on a periodic tick.
- The tick comes from the strobe output of the team's counter_with_strobe block, which sets the sample rate.
- Produces a clean level plus single-cycle rise/fall event pulses for downstream control logic (buttons, limit switches, slow external status lines).

Parameters:
- WIDTH, 8, width of the stable-sample counter and the threshold input.
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer; legal range 2..4.
- INIT_LEVEL, 0, value of dout and of every synchronizer stage while in reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset: asserts immediately when LOW, releases on the clock edge after going HIGH.
- tick  in  1  sample enable, one clk cycle wide; driven by the strobe of counter_with_strobe.
- din  in  1  raw asynchronous input.
- threshold  in  WIDTH  number of consecutive differing samples required to accept a change; 0 behaves as 1.
- dout  out  1  debounced level.
- rise  out  1  one-cycle pulse in the cycle dout goes 0->1.
- fall  out  1  one-cycle pulse in the cycle dout goes 1->0.
- busy  out  1  HIGH while in QUALIFY.

Behaviour:
- Reset (rst LOW), all asynchronous:
  - dout = INIT_LEVEL; synchronizer stages = INIT_LEVEL.
  - count = 0; state = IDLE; rise = fall = busy = 0.
- Synchronizer:
  - Shifts din every clk, independent of tick.
  - s = last stage.
- Tick gating: count and state change only in cycles where tick = 1. With tick = 0, only the synchronizer advances, and rise/fall clear to 0.
- eff_thr = (threshold == 0) ? 1 : threshold.
- States:
  - IDLE, on tick:
    - s == dout: stay; count = 0.
    - s != dout and eff_thr == 1: accept immediately (see accept).
    - s != dout otherwise: count = 1; go QUALIFY.
  - QUALIFY, on tick:
    - s == dout: bounce; count = 0; go IDLE.
    - s != dout and count + 1 >= eff_thr: accept.
    - s != dout otherwise: count = count + 1.
  - accept: dout <= ~dout, count <= 0, state <= IDLE. On the same edge, rise <= ~dout_old or fall <= dout_old. The pulse is visible the cycle dout changes and lasts exactly one clk.
- busy = (state == QUALIFY), registered.
- Comparison is >=, not ==. If threshold drops below count mid-qualification, the change is accepted on the next differing tick. If threshold rises, qualification continues to the new value.
- count is WIDTH bits and never exceeds eff_thr - 1, so no wrap. Threshold = 2^WIDTH - 1 is legal.
- Latency: a clean din edge reaches dout after SYNC_STAGES clk cycles for synchronization, plus eff_thr ticks, plus 0 extra clk after the accepting tick.
- Simultaneous events:
  - tick and rst LOW in the same cycle: reset wins.
  - A din change that has not yet reached s is not seen by that tick.
- Reset mid-QUALIFY abandons the qualification; no pulse is emitted.
- rise and fall are never HIGH together. Neither can be HIGH in two consecutive cycles, since tick is one cycle wide.
- tick held HIGH continuously is legal: sampling then occurs every clk.

Test Plan:
- Reset: INIT_LEVEL=0, hold rst LOW 3 clk, toggle din -> dout=0, rise=fall=busy=0 throughout; dout stays 0 after release with din=0.
- Clean edge: threshold=4, tick every 10 clk, din 0->1 held -> after sync, busy HIGH; on the 4th tick, dout=1 with a single one-cycle rise; busy LOW the next cycle.
- Bounce rejection: threshold=4, din HIGH for 3 ticks then LOW before the 4th tick -> dout stays 0, no rise, busy drops on the returning tick, count back to 0.
- Zero/one threshold: threshold=0, then 1, din 1->0 with dout=1 -> dout=0 and fall pulse on the first tick seeing s=0, busy never HIGH.
- Threshold change mid-qualify: threshold=10, 5 differing ticks, then threshold=3 -> accept on the 6th tick; rise once.
- Async reset mid-qualify: threshold=8, rst LOW after 5 ticks -> dout=INIT_LEVEL immediately, no pulse; after release, the full 8 ticks are required again.

Source files
------------

// File: rtl/strobe_debouncer.sv
// -----------------------------------------------------------------------------
// strobe_debouncer
//
// Debounces and qualifies one asynchronous input. The input is synchronized
// every clock, but it is only sampled when tick is HIGH. tick is normally the
// strobe of a counter_with_strobe, so the strobe period sets the sample rate.
// A change on the synchronized input is accepted only after it has been seen
// on threshold consecutive ticks. A threshold of 0 is treated as 1.
//
// Parameters:
//   WIDTH       width of the stable-sample counter and of threshold
//   SYNC_STAGES number of synchronizer flip-flops, legal range 2..4
//   INIT_LEVEL  value of dout and of every synchronizer stage during reset
//
// Ports:
//   clk       in   system clock; all state changes on the rising edge
//   rst       in   asynchronous active-low reset
//   tick      in   sample enable, one clk cycle wide
//   din       in   raw asynchronous input
//   threshold in   consecutive differing samples needed to accept a change
//   dout      out  debounced level
//   rise      out  one-cycle pulse in the cycle dout goes 0->1
//   fall      out  one-cycle pulse in the cycle dout goes 1->0
//   busy      out  HIGH while a change is being qualified
// -----------------------------------------------------------------------------
module strobe_debouncer #(
    parameter int   WIDTH       = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             din,
    input  logic [WIDTH-1:0] threshold,
    output logic             dout,
    output logic             rise,
    output logic             fall,
    output logic             busy
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] QUALIFY = 1'b1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dout;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_busy;
    logic [WIDTH-1:0]       r_count;
    logic [0:0]             r_state;

    logic                   w_s;
    logic [WIDTH-1:0]       w_eff_thr;
    logic [WIDTH:0]         w_cnt_inc;
    logic                   w_reached;
    logic                   w_accept;
    logic [WIDTH-1:0]       w_count_nxt;
    logic [0:0]             w_state_nxt;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_eff_thr = (threshold == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : threshold;
    // One bit wider than the counter so the increment can never wrap before
    // the compare, even with the largest legal threshold.
    assign w_cnt_inc = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    // >= rather than == so that lowering threshold below the current count
    // accepts on the next differing tick instead of never matching.
    assign w_reached = (w_cnt_inc >= {1'b0, w_eff_thr});

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_accept    = 1'b0;
        if (tick) begin
            case (r_state)
                IDLE: begin
                    if (w_s == r_dout) begin
                        w_count_nxt = '0;
                    end else if (w_eff_thr == {{(WIDTH-1){1'b0}}, 1'b1}) begin
                        w_accept = 1'b1;
                    end else begin
                        w_count_nxt = {{(WIDTH-1){1'b0}}, 1'b1};
                        w_state_nxt = QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (w_s == r_dout) begin
                        // Input bounced back before qualifying.
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end else if (w_reached) begin
                        w_accept = 1'b1;
                    end else begin
                        w_count_nxt = w_cnt_inc[WIDTH-1:0];
                    end
                end
                default: begin
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            endcase
            if (w_accept) begin
                w_count_nxt = '0;
                w_state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= {SYNC_STAGES{INIT_LEVEL}};
            r_dout  <= INIT_LEVEL;
            r_count <= '0;
            r_state <= IDLE;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], din};
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
            // Pulses are registered on the same edge as dout so they line up
            // with the level change and clear on the following clock.
            r_rise  <= w_accept & ~r_dout;
            r_fall  <= w_accept &  r_dout;
            r_busy  <= (w_state_nxt == QUALIFY);
            if (w_accept) begin
                r_dout <= ~r_dout;
            end
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;

endmodule
